// File: rtl/sbox_sched_if.sv
// Bundles the key-expansion port, the state SubBytes port and the four shared
// external S-box lanes of sbox_sched.
interface sbox_sched_if;
  logic         key_req;
  logic [31:0]  key_word;
  logic         key_ack;
  logic [31:0]  key_sub;
  logic         st_req;
  logic [127:0] st_data;
  logic         st_busy;
  logic         st_done;
  logic [127:0] st_sub;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic [1:0]   sb_own;

  modport slave (
    input  key_req, key_word, st_req, st_data, sb_out,
    output key_ack, key_sub, st_busy, st_done, st_sub, sb_in, sb_own
  );

  modport master (
    output key_req, key_word, st_req, st_data, sb_out,
    input  key_ack, key_sub, st_busy, st_done, st_sub, sb_in, sb_own
  );
endinterface

// File: rtl/sbox_sched.sv
// Time-shares four external combinational S-box lanes between single-word key
// SubWord requests (priority) and four-column AES state SubBytes operations.
module sbox_sched (
  input  logic        clk,
  input  logic        rst_n,
  sbox_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_KEY   = 2'b01;
  localparam logic [1:0] OWN_STATE = 2'b10;

  logic [1:0]   state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [127:0] st_sub_q, st_sub_d;
  logic [31:0]  key_sub_q, key_sub_d;
  logic         key_ack_q, key_ack_d;
  logic         key_gnt;
  logic [6:0]   col_base;
  logic [31:0]  sb_in;
  logic [1:0]   sb_own;

  // A request is never granted in its own ack cycle; gating with rst_n keeps the lanes idle in reset.
  assign key_gnt  = rst_n & bus.key_req & ~key_ack_q;
  assign col_base = {col_q, 5'd0};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    col_d     = col_q;
    data_d    = data_q;
    st_sub_d  = st_sub_q;
    key_sub_d = key_sub_q;
    key_ack_d = key_gnt;
    sb_in     = '0;
    sb_own    = OWN_NONE;

    if (key_gnt) begin
      sb_in     = bus.key_word;
      sb_own    = OWN_KEY;
      key_sub_d = bus.sb_out;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.st_req) begin
          data_d  = bus.st_data;
          col_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!key_gnt) begin
          sb_in                   = data_q[col_base +: 32];
          sb_own                  = OWN_STATE;
          st_sub_d[col_base +: 32] = bus.sb_out;
          col_d                   = col_q + 2'd1;
          if (col_q == 2'd3) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      st_sub_q  <= '0;
      key_sub_q <= '0;
      key_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      st_sub_q  <= st_sub_d;
      key_sub_q <= key_sub_d;
      key_ack_q <= key_ack_d;
    end
  end

  // NOTE: the captured state is only read after a fresh capture, so this wide register carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.key_ack = key_ack_q;
  assign bus.key_sub = key_sub_q;
  assign bus.st_busy = (state_q == ST_RUN);
  assign bus.st_done = (state_q == ST_DONE);
  assign bus.st_sub  = st_sub_q;
  assign bus.sb_in   = sb_in;
  assign bus.sb_own  = sb_own;

endmodule
